// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and feeder FSM encoding
package pe_pkg;
  localparam int CELL_BIT = 8;
  localparam int N_CELL = 9;
  localparam int MAX_W = 32;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
endpackage

// File: rtl/pe_line_buf.sv
// pe_line_buf: one image line of pixels, read-before-write at a shared address
module pe_line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign rdata = mem[addr];
  // contents are never cleared; stale data is masked by the feeder's row/col gating
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/pe_window_feeder.sv
// pe_window_feeder: turns a raster pixel stream into valid 3x3 convolution windows
module pe_window_feeder
  import pe_pkg::*;
#(
  parameter int CELL_BIT = pe_pkg::CELL_BIT,
  parameter int MAX_W = pe_pkg::MAX_W,
  parameter int CNT_W = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [CNT_W-1:0]           cfg_width,
  input  logic [CNT_W-1:0]           cfg_height,
  input  logic [CELL_BIT-1:0]        pix_in,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  output logic [N_CELL*CELL_BIT-1:0] win,
  output logic                       win_en,
  output logic                       win_last,
  output logic                       done,
  output logic                       err
);
  localparam int AW = $clog2(MAX_W);
  state_t state, nxt;
  logic [CNT_W-1:0] col, row, w, h;
  logic [N_CELL*CELL_BIT-1:0] sh, shifted;
  logic [CELL_BIT-1:0] lb0_q, lb1_q;
  logic acc, legal, col_end, last_px, inner;
  assign pix_ready = state == ACTIVE;
  assign acc = pix_valid && pix_ready;
  assign legal = cfg_width >= CNT_W'(3) && cfg_width <= CNT_W'(MAX_W) && cfg_height >= CNT_W'(3);
  assign col_end = col == w - CNT_W'(1);
  assign last_px = col_end && row == h - CNT_W'(1);
  assign inner = row >= CNT_W'(2) && col >= CNT_W'(2);
  pe_line_buf #(.DEPTH(MAX_W), .WIDTH(CELL_BIT)) u_lb0 (
    .clk(clk), .we(acc), .addr(col[AW-1:0]), .wdata(pix_in), .rdata(lb0_q)
  );
  pe_line_buf #(.DEPTH(MAX_W), .WIDTH(CELL_BIT)) u_lb1 (
    .clk(clk), .we(acc), .addr(col[AW-1:0]), .wdata(lb0_q), .rdata(lb1_q)
  );
  // window shifted one column left with the incoming column on the right
  always_comb begin
    shifted = sh;
    for (int r = 0; r < 3; r++) begin
      shifted[CELL_BIT*(3*r)+:CELL_BIT] = sh[CELL_BIT*(3*r+1)+:CELL_BIT];
      shifted[CELL_BIT*(3*r+1)+:CELL_BIT] = sh[CELL_BIT*(3*r+2)+:CELL_BIT];
    end
    shifted[CELL_BIT*2+:CELL_BIT] = lb1_q;
    shifted[CELL_BIT*5+:CELL_BIT] = lb0_q;
    shifted[CELL_BIT*8+:CELL_BIT] = pix_in;
  end
  // frame sequencing: idle until a legal start, active until the last pixel, one done cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start && legal ? ACTIVE : IDLE;
      ACTIVE:  nxt = acc && last_px ? DONE : ACTIVE;
      default: nxt = IDLE;
    endcase
  end
  // state, counters, window shift register and registered outputs
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      w <= '0;
      h <= '0;
      sh <= '0;
      win <= '0;
      win_en <= 1'b0;
      win_last <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      win_en <= acc && inner;
      win_last <= acc && last_px;
      done <= state == DONE;
      err <= state == IDLE && start && !legal;
      if (state == IDLE && start && legal) begin
        w <= cfg_width;
        h <= cfg_height;
        col <= '0;
        row <= '0;
      end
      if (acc) begin
        sh <= shifted;
        col <= col_end ? '0 : col + CNT_W'(1);
        row <= col_end ? row + CNT_W'(1) : row;
        if (inner) win <= shifted;
      end
    end
endmodule

// File: tb/tb_pe_window_feeder.sv
// tb_pe_window_feeder: directed frames with random pixels/gaps against an image-level window model
module tb_pe_window_feeder;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [5:0] cfg_width = '0, cfg_height = '0;
  logic [7:0] pix_in = '0;
  logic pix_ready, win_en, win_last, done, err;
  logic [71:0] win, last_win;
  logic [7:0] img [0:2047];
  int vectors = 0, miscompares = 0;

  pe_window_feeder dut (
    .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready), .win(win),
    .win_en(win_en), .win_last(win_last), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] window(input int n, input int w);
    logic [71:0] res;
    int r, c;
    r = n / w;
    c = n % w;
    res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res[8*(3*i+j)+:8] = img[(r-2+i)*w + (c-2+j)];
    return res;
  endfunction

  task automatic run_frame(input int w, input int h, input int gap, input bit rnd,
                           input int base, input int abort_at, input bit mid_start);
    int n, wins, cyc;
    bit v, acc, exp_en;
    logic [71:0] ew;
    n = 0;
    wins = 0;
    cyc = 0;
    for (int i = 0; i < w*h; i++) img[i] = rnd ? 8'($urandom) : 8'(base + i);
    cfg_width = 6'(w);
    cfg_height = 6'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_no_err", 72'(err), 72'(0));
    chk("start_ready", 72'(pix_ready), 72'(1));
    while (n < w*h && n != abort_at && cyc < 4000) begin
      cyc++;
      v = gap == 0 ? 1'b1 : gap == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      pix_valid = v;
      pix_in = img[n];
      start = mid_start && cyc == 3;
      if (start) cfg_width = 6'd2;
      acc = v && pix_ready;
      exp_en = acc && (n / w) >= 2 && (n % w) >= 2;
      ew = exp_en ? window(n, w) : last_win;
      tick();
      start = 1'b0;
      chk("win_en", 72'(win_en), 72'(exp_en));
      chk("err_quiet", 72'(err), 72'(0));
      if (exp_en) begin
        wins++;
        chk("win", win, ew);
        chk("win_last", 72'(win_last), 72'(n == w*h-1));
        last_win = ew;
      end else begin
        chk("win_hold", win, last_win);
        chk("win_last_low", 72'(win_last), 72'(0));
      end
      if (acc) n++;
    end
    pix_valid = 1'b0;
    if (abort_at < 0) begin
      chk("timeout", 72'(cyc < 4000), 72'(1));
      chk("win_count", 72'(wins), 72'((w-2)*(h-2)));
      tick();
      chk("done", 72'(done), 72'(1));
      chk("done_no_win", 72'(win_en), 72'(0));
      tick();
      chk("done_pulse", 72'(done), 72'(0));
      chk("idle_ready", 72'(pix_ready), 72'(0));
    end
  endtask

  task automatic bad_start(input int w, input int h);
    cfg_width = 6'(w);
    cfg_height = 6'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_pulse", 72'(err), 72'(1));
    chk("err_ready", 72'(pix_ready), 72'(0));
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    chk("err_clear", 72'(err), 72'(0));
    chk("err_ready2", 72'(pix_ready), 72'(0));
    chk("err_no_win", 72'(win_en), 72'(0));
  endtask

  initial begin
    last_win = '0;
    tick();
    tick();
    chk("rst_ready", 72'(pix_ready), 72'(0));
    chk("rst_win", win, 72'(0));
    chk("rst_flags", 72'({win_en, win_last, done, err}), 72'(0));
    reset = 1'b1;
    tick();
    run_frame(4, 4, 0, 1'b0, 0, -1, 1'b0);
    run_frame(4, 4, 1, 1'b0, 0, -1, 1'b0);
    bad_start(2, 4);
    bad_start(4, 2);
    bad_start(33, 4);
    run_frame(4, 4, 0, 1'b0, 0, 10, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    last_win = '0;
    chk("mid_rst_ready", 72'(pix_ready), 72'(0));
    chk("mid_rst_win", win, 72'(0));
    chk("mid_rst_flags", 72'({win_en, win_last, done, err}), 72'(0));
    run_frame(4, 4, 0, 1'b0, 100, -1, 1'b0);
    run_frame(32, 3, 2, 1'b1, 0, -1, 1'b0);
    run_frame(5, 5, 0, 1'b1, 0, -1, 1'b1);
    for (int k = 0; k < 4; k++)
      run_frame($urandom_range(3, 32), $urandom_range(3, 6), 2, 1'b1, 0, -1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
